// File: rtl/cpu_int_sched.sv
// Hardware interrupt front end: synchronises NMI/IRQ, arbitrates priority, supplies vectors, owns WAI/STP.
// Latency: sources enter after SYNC_STAGES flops, NMI pending one cycle later, take_int one cycle after the decision.
// Backpressure: none; requests stay pending until the CPU reads the vector. Optional ABORT input: CPU_INT_ABORT_EN.
module cpu_int_sched #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        p_i,
  input  logic        e_mode,
  input  logic        boundary,
  input  logic        vec_fetch,
  input  logic        int_done,
  input  logic        sw_cop,
  input  logic        wai,
  input  logic        stp,
`ifdef CPU_INT_ABORT_EN
  input  logic        abort_n,
`endif
  output logic        take_int,
  output logic [1:0]  int_kind,
  output logic [15:0] vector_addr,
  output logic        halted,
  output logic        wake
);

  localparam logic [1:0] K_RESET = 2'd0;
  localparam logic [1:0] K_NMI   = 2'd1;
  localparam logic [1:0] K_IRQ   = 2'd2;
  localparam logic [1:0] K_ABORT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_TAKEN, S_WAIT, S_STOP} state_t;

  // Source bus: bit 0 IRQ (level), bit 1 NMI (edge), bit 2 ABORT (edge, optional).
`ifdef CPU_INT_ABORT_EN
  localparam int NSRC = 3;
`else
  localparam int NSRC = 2;
`endif

  logic [NSRC-1:0] src_n;
  logic [NSRC-1:0] src_s;
  logic [NSRC-1:1] edge_prev_q;
  logic [NSRC-1:1] src_fall;

`ifdef CPU_INT_ABORT_EN
  assign src_n = {abort_n, nmi_n, irq_n};
`else
  assign src_n = {nmi_n, irq_n};
`endif

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = src_n;
    end else begin : g_sync
      logic [NSRC-1:0] sync_q [SYNC_STAGES];
      // Metastability chain; idles high so reset never looks like a falling edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
          sync_q[0] <= src_n;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign src_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Previous synchronised level of the edge-triggered sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_prev_q <= '1;
    else          edge_prev_q <= src_s[NSRC-1:1];
  end

  assign src_fall = edge_prev_q & ~src_s[NSRC-1:1];

  state_t     state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic       reset_pend_q, reset_pend_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       abort_pend;
  logic       taken_clr;
  logic       irq_act;
  logic       req;
  logic [1:0] win_kind;

  // The vector read retires the pending flag of the kind being serviced.
  assign taken_clr    = (state_q == S_TAKEN) & vec_fetch;
  assign reset_pend_d = reset_pend_q & ~(taken_clr & (kind_q == K_RESET));
  // A new edge wins over a same-cycle clear so it is never lost.
  assign nmi_pend_d   = src_fall[1] | (nmi_pend_q & ~(taken_clr & (kind_q == K_NMI)));

`ifdef CPU_INT_ABORT_EN
  logic abort_pend_q, abort_pend_d;
  assign abort_pend_d = src_fall[2] | (abort_pend_q & ~(taken_clr & (kind_q == K_ABORT)));
  // Pending ABORT flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) abort_pend_q <= 1'b0;
    else          abort_pend_q <= abort_pend_d;
  end
  assign abort_pend = abort_pend_q;
`else
  assign abort_pend = 1'b0;
`endif

  assign irq_act  = ~src_s[0] & ~p_i;
  assign req      = reset_pend_q | abort_pend | nmi_pend_q | irq_act;
  assign win_kind = reset_pend_q ? K_RESET :
                    abort_pend   ? K_ABORT :
                    nmi_pend_q   ? K_NMI   : K_IRQ;

  // State, latched kind and pending flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      kind_q       <= K_RESET;
      reset_pend_q <= 1'b1;
      nmi_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      reset_pend_q <= reset_pend_d;
      nmi_pend_q   <= nmi_pend_d;
    end
  end

  // Next-state, halt gate and wake pulse; WAI/STP beat a same-cycle boundary.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    halted  = 1'b0;
    wake    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stp) begin
          state_d = S_STOP;
        end else if (wai) begin
          state_d = S_WAIT;
        end else if (reset_pend_q | (boundary & req)) begin
          state_d = S_TAKEN;
          kind_d  = win_kind;
        end
      end
      S_TAKEN: begin
        if (int_done) state_d = S_IDLE;
      end
      S_WAIT: begin
        // Wake ignores P[I]: a masked IRQ just resumes execution.
        if (nmi_pend_q | ~src_s[0]) begin
          wake    = 1'b1;
          state_d = S_IDLE;
        end else begin
          halted  = 1'b1;
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

  assign take_int = (state_q == S_TAKEN);
  assign int_kind = kind_q;

  // Vector: hardware kind while taking an interrupt, otherwise the BRK/COP vector.
  always_comb begin
    vector_addr = 16'hFFFC;
    if (state_q == S_TAKEN) begin
      case (kind_q)
        K_RESET: vector_addr = 16'hFFFC;
        K_NMI:   vector_addr = e_mode ? 16'hFFFA : 16'hFFEA;
        K_IRQ:   vector_addr = e_mode ? 16'hFFFE : 16'hFFEE;
        default: vector_addr = e_mode ? 16'hFFF8 : 16'hFFE8;
      endcase
    end else if (sw_cop) begin
      vector_addr = e_mode ? 16'hFFF4 : 16'hFFE4;
    end else begin
      vector_addr = e_mode ? 16'hFFFE : 16'hFFE6;
    end
  end

endmodule
